microseq_controller: RTL

- Microprogram sequencer that drives the control address register (CAR) of the microprogrammed CPU.
- Each cycle it picks the next control-memory address from the current microinstruction's branch field, condition field and address field, and from the instruction opcode.
- A start/halt state machine gates sequencing. A stall input freezes it while memory or I/O is busy.
- Its `advance` output qualifies the write-enable, clear and increment controls of the datapath registers, so they act only on cycles where the microinstruction actually executes.

---
 rtl/microseq_controller.sv | 105 ++++++++++
 1 files changed

// File: rtl/microseq_controller.sv
// Microprogram sequencer: next control-address selection for the CAR,
// one-level subroutine register and a start/run/halt gate with stall.
module microseq_controller #(
  parameter int ADDR_W     = 7,
  parameter int OP_W       = 4,
  parameter int MAP_SHIFT  = 2,
  parameter int FETCH_ADDR = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              halt_uop,
  input  logic [1:0]        br,
  input  logic [1:0]        cd,
  input  logic [ADDR_W-1:0] ad,
  input  logic [OP_W-1:0]   opcode,
  input  logic              cond_i,
  input  logic              ac_sign,
  input  logic              ac_zero,
  output logic [ADDR_W-1:0] car,
  output logic              running,
  output logic              halted,
  output logic              advance
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [1:0] BR_JMP  = 2'b00;
  localparam logic [1:0] BR_CALL = 2'b01;
  localparam logic [1:0] BR_RET  = 2'b10;
  localparam logic [1:0] BR_MAP  = 2'b11;

  localparam logic [ADDR_W-1:0] FETCH = ADDR_W'(FETCH_ADDR);

  state_t            state, state_n;
  logic [ADDR_W-1:0] sbr, sbr_n, car_n;
  logic [ADDR_W-1:0] car_inc, map_addr;
  logic              c;

  assign car_inc  = car + ADDR_W'(1);
  assign map_addr = ADDR_W'(opcode) << MAP_SHIFT;

  always_comb begin
    c = 1'b1;
    unique case (cd)
      2'b00: c = 1'b1;
      2'b01: c = cond_i;
      2'b10: c = ac_sign;
      2'b11: c = ac_zero;
    endcase
  end

  always_comb begin
    state_n = state;
    car_n   = car;
    sbr_n   = sbr;
    unique case (state)
      IDLE, HALT: begin
        if (start) begin
          state_n = RUN;
          car_n   = FETCH;
        end
      end
      RUN: begin
        // Halt leaves car on the HALT microinstruction itself
        if (!stall && halt_uop) begin
          state_n = HALT;
        end else if (!stall) begin
          unique case (br)
            BR_JMP:  car_n = c ? ad : car_inc;
            BR_CALL: begin
              car_n = c ? ad : car_inc;
              if (c) sbr_n = car_inc;
            end
            BR_RET:  car_n = sbr;
            BR_MAP:  car_n = map_addr;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      car   <= '0;
      sbr   <= '0;
    end else begin
      state <= state_n;
      car   <= car_n;
      sbr   <= sbr_n;
    end
  end

  assign running = (state == RUN);
  assign halted  = (state == HALT);
  assign advance = running & ~stall;

endmodule
